// File: rtl/ctlr_poll_engine.sv
// Purpose : autonomous N-port serial pad poller with atomic snapshot and CPU read port at BASE_ADDR+p.
// Latency : capture = PULSE_LEN + NUM_BITS + 2*PULSE_LEN*(NUM_BITS-1) + 1 ticks; CPU read data valid one tick after the read.
// Backpressure: none on the CPU side; capture requests arriving while busy queue one deep (pending), further ones merge.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   clock_en            - CPU tick enable; every register advances only when high
//   addr, r_en, w_data  - CPU bus: write to BASE_ADDR sets strobe, read of BASE_ADDR+p returns port p
//   ctlr_data           - serial pad data per port, active-low on the wire
//   ctlr_pulse          - pad shift clock per port, idle high
//   ctlr_latch          - pad parallel load, active-high
//   button_data_rd      - registered read data {7'b0, bit}
//   rd_hit              - registered: previous tick was a read of a mapped port
//   busy                - capture sequencer is not idle
module ctlr_poll_engine #(
    parameter int          NUM_PORTS   = 2,
    parameter int          NUM_BITS    = 8,
    parameter int          PULSE_LEN   = 3,
    parameter int          AUTO_POLL   = 0,
    parameter int          POLL_PERIOD = 29780,
    parameter logic [15:0] BASE_ADDR   = 16'h4016
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clock_en,
    input  logic [15:0]          addr,
    input  logic                 r_en,
    input  logic [7:0]           w_data,
    input  logic [NUM_PORTS-1:0] ctlr_data,
    output logic [NUM_PORTS-1:0] ctlr_pulse,
    output logic                 ctlr_latch,
    output logic [7:0]           button_data_rd,
    output logic                 rd_hit,
    output logic                 busy
);

    localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int PW = $clog2(NUM_BITS + 1);
    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PULSE_LEN - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(NUM_BITS - 1);
    localparam logic [PW-1:0] PTR_END   = PW'(NUM_BITS);
    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SAMPLE,
        S_CLK_LO,
        S_CLK_HI,
        S_COMMIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       bit_idx;
    logic                strobe;
    logic                pending;
    logic [TW-1:0]       poll_cnt;
    logic [NUM_BITS-1:0] staging  [NUM_PORTS];
    logic [NUM_BITS-1:0] snapshot [NUM_PORTS];
    logic [PW-1:0]       rd_ptr   [NUM_PORTS];

    logic                wr_strobe;
    logic                strobe_nxt;
    logic                strobe_fall;
    logic                poll_wrap;
    logic                cap_req;
    logic                cnt_last;
    logic                rd_any;
    logic                rd_bit;
    logic [NUM_PORTS-1:0] rd_sel;
    logic [NUM_BITS-1:0] rd_shift;
    logic                unused_wdata;

    assign unused_wdata = ^w_data[7:1];

    assign wr_strobe   = !r_en && (addr == BASE_ADDR);
    assign strobe_nxt  = wr_strobe ? w_data[0] : strobe;
    assign strobe_fall = wr_strobe && strobe && !w_data[0];
    assign poll_wrap   = (AUTO_POLL != 0) && (poll_cnt == POLL_LAST);
    assign cap_req     = strobe_fall || poll_wrap;
    assign cnt_last    = (cnt == CNT_LAST);

    // Read decode: past the last bit a port reads back 1, like an exhausted pad shift register.
    always_comb begin
        rd_any   = 1'b0;
        rd_bit   = 1'b0;
        rd_sel   = '0;
        rd_shift = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_en && (addr == BASE_ADDR + 16'(p))) begin
                rd_any    = 1'b1;
                rd_sel[p] = 1'b1;
                rd_shift  = snapshot[p] >> rd_ptr[p];
                rd_bit    = (rd_ptr[p] < PTR_END) ? rd_shift[0] : 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (clock_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctlr_latch = 1'b0;
        ctlr_pulse = '1;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (cap_req) state_nxt = S_LATCH;
            S_LATCH: begin
                ctlr_latch = 1'b1;
                if (cnt_last) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: state_nxt = (bit_idx == BIT_LAST) ? S_COMMIT : S_CLK_LO;
            S_CLK_LO: begin
                ctlr_pulse = '0;
                if (cnt_last) state_nxt = S_CLK_HI;
            end
            S_CLK_HI: if (cnt_last) state_nxt = S_SAMPLE;
            // A request landing on the commit tick restarts straight away, same as a queued one.
            S_COMMIT: state_nxt = (pending || cap_req) ? S_LATCH : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= '0;
            bit_idx        <= '0;
            strobe         <= 1'b0;
            pending        <= 1'b0;
            poll_cnt       <= '0;
            button_data_rd <= '0;
            rd_hit         <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                staging[p]  <= '0;
                snapshot[p] <= '0;
                rd_ptr[p]   <= '0;
            end
        end else if (clock_en) begin
            strobe <= strobe_nxt;

            // Phase timer restarts on every state change.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (state == S_LATCH || state == S_CLK_LO || state == S_CLK_HI) begin
                cnt <= cnt + 1'b1;
            end

            if (state == S_LATCH) begin
                bit_idx <= '0;
            end else if (state == S_CLK_HI && cnt_last) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (state == S_COMMIT) begin
                pending <= 1'b0;
            end else if (cap_req && state != S_IDLE) begin
                pending <= 1'b1;
            end

            if (AUTO_POLL != 0) begin
                poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            end

            if (state == S_SAMPLE) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    staging[p][bit_idx] <= ~ctlr_data[p];
                end
            end

            rd_hit <= rd_any;
            if (rd_any) begin
                button_data_rd <= {7'b0, rd_bit};
            end

            // Commit beats everything; strobe (including the write that raises it) holds pointers at 0.
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state == S_COMMIT || strobe_nxt) begin
                    rd_ptr[p] <= '0;
                end else if (rd_sel[p] && rd_ptr[p] != PTR_END) begin
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                end
            end

            if (state == S_COMMIT) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    snapshot[p] <= staging[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_ctlr_poll_engine.sv
// Purpose : directed bench for ctlr_poll_engine (strobe capture, reads, queued request, reset abort, auto-poll).
// Latency : expectations are counted in clock_en ticks from the strobe-fall write tick (tick 0).
// Backpressure: n/a.
module tb_ctlr_poll_engine;

    localparam logic [15:0] BASE = 16'h4016;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        clock_en;
    logic [15:0] addr;
    logic        r_en;
    logic [7:0]  w_data;
    logic [1:0]  ctlr_data;
    logic [1:0]  ctlr_pulse;
    logic        ctlr_latch;
    logic [7:0]  button_data_rd;
    logic        rd_hit;
    logic        busy;

    logic        clock_en2;
    logic [1:0]  ctlr_pulse2;
    logic        ctlr_latch2;
    logic [7:0]  button_data_rd2;
    logic        rd_hit2;
    logic        busy2;

    ctlr_poll_engine #(
        .NUM_PORTS(2), .NUM_BITS(8), .PULSE_LEN(3),
        .AUTO_POLL(0), .POLL_PERIOD(29780), .BASE_ADDR(16'h4016)
    ) dut (
        .clock(clock), .reset(reset), .clock_en(clock_en),
        .addr(addr), .r_en(r_en), .w_data(w_data),
        .ctlr_data(ctlr_data), .ctlr_pulse(ctlr_pulse), .ctlr_latch(ctlr_latch),
        .button_data_rd(button_data_rd), .rd_hit(rd_hit), .busy(busy)
    );

    ctlr_poll_engine #(
        .NUM_PORTS(2), .NUM_BITS(8), .PULSE_LEN(3),
        .AUTO_POLL(1), .POLL_PERIOD(100), .BASE_ADDR(16'h4016)
    ) dut_auto (
        .clock(clock), .reset(reset), .clock_en(clock_en2),
        .addr(16'h0000), .r_en(1'b1), .w_data(8'h00),
        .ctlr_data(2'b11), .ctlr_pulse(ctlr_pulse2), .ctlr_latch(ctlr_latch2),
        .button_data_rd(button_data_rd2), .rd_hit(rd_hit2), .busy(busy2)
    );

    // Pad model: 4021-style shift register, reloaded by latch, advanced on pulse rising edge.
    logic [7:0] pad_btn0;
    logic [7:0] pad_btn1;
    logic [3:0] pad_idx = 4'd0;

    always @(posedge ctlr_latch or posedge ctlr_pulse[0]) begin
        if (ctlr_latch) pad_idx <= 4'd0;
        else if (pad_idx != 4'd8) pad_idx <= pad_idx + 4'd1;
    end

    assign ctlr_data[0] = pad_idx[3] ? 1'b0 : ~pad_btn0[pad_idx[2:0]];
    assign ctlr_data[1] = pad_idx[3] ? 1'b0 : ~pad_btn1[pad_idx[2:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        r_en   = 1'b1;
        addr   = 16'h0000;
        w_data = 8'h00;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        r_en   = 1'b0;
        addr   = a;
        w_data = d;
        tick();
        idle_bus();
    endtask

    task automatic cpu_read_chk(input string tag, input logic [15:0] a, input logic b);
        r_en = 1'b1;
        addr = a;
        tick();
        chk({tag, "_data"}, 32'(button_data_rd), 32'({7'b0, b}));
        chk({tag, "_hit"}, 32'(rd_hit), 32'd1);
        idle_bus();
    endtask

    int         busy_cnt, busy_first, busy_last;
    int         latch_cnt, latch_first, latch_last, latch_rise;
    int         lo_cnt, lo_fall, lo_first, mixed;
    logic [1:0] prev_pulse;
    logic       prev_latch;
    logic       latch_at55;
    logic [9:0] exp_seq;
    logic [7:0] rd_val;

    initial begin
        reset     = 1'b1;
        clock_en  = 1'b1;
        clock_en2 = 1'b0;
        pad_btn0  = 8'b1010_0101;
        pad_btn1  = 8'b0011_0110;
        idle_bus();
        tick();
        tick();
        reset = 1'b0;

        chk("rst_latch", 32'(ctlr_latch), 32'd0);
        chk("rst_pulse", 32'(ctlr_pulse), 32'h3);
        chk("rst_data",  32'(button_data_rd), 32'd0);
        chk("rst_hit",   32'(rd_hit), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_busy_auto", 32'(busy2), 32'd0);

        // ---- 1: basic strobe-triggered capture and serial read-out ----
        cpu_write(BASE, 8'h01);
        r_en = 1'b0; addr = BASE; w_data = 8'h00;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        latch_cnt = 0; latch_first = -1; latch_last = -1;
        lo_cnt = 0; lo_fall = 0; lo_first = -1; mixed = 0;
        prev_pulse = 2'b11;
        for (int t = 0; t <= 60; t++) begin
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = t;
                busy_last = t;
            end
            if (ctlr_latch) begin
                latch_cnt++;
                if (latch_first < 0) latch_first = t;
                latch_last = t;
            end
            if (ctlr_pulse == 2'b00) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = t;
                if (prev_pulse == 2'b11) lo_fall++;
            end else if (ctlr_pulse != 2'b11) begin
                mixed++;
            end
            prev_pulse = ctlr_pulse;
            tick();
            idle_bus();
        end
        chk("t1_busy_cnt",   32'(busy_cnt), 32'd54);
        chk("t1_busy_first", 32'(busy_first), 32'd1);
        chk("t1_busy_last",  32'(busy_last), 32'd54);
        chk("t1_latch_cnt",  32'(latch_cnt), 32'd3);
        chk("t1_latch_first", 32'(latch_first), 32'd1);
        chk("t1_latch_last", 32'(latch_last), 32'd3);
        chk("t1_pulse_falls", 32'(lo_fall), 32'd7);
        chk("t1_pulse_low_ticks", 32'(lo_cnt), 32'd21);
        chk("t1_pulse_first_low", 32'(lo_first), 32'd5);
        chk("t1_pulse_mixed", 32'(mixed), 32'd0);

        exp_seq = {2'b11, 8'b1010_0101};
        for (int i = 0; i < 10; i++) begin
            cpu_read_chk($sformatf("t1_rd%0d", i), BASE, exp_seq[0]);
            exp_seq = exp_seq >> 1;
        end
        r_en = 1'b1; addr = 16'h4018;
        tick();
        chk("t1_unmapped_hit",  32'(rd_hit), 32'd0);
        chk("t1_unmapped_hold", 32'(button_data_rd), 32'd1);
        idle_bus();

        // ---- 2: strobe held keeps pointers at 0 ----
        cpu_read_chk("t2_pre_p1_b0", BASE + 16'd1, 1'b0);
        cpu_read_chk("t2_pre_p1_b1", BASE + 16'd1, 1'b1);
        cpu_read_chk("t2_pre_p1_b2", BASE + 16'd1, 1'b1);
        cpu_write(BASE, 8'h01);
        chk("t2_no_capture", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) cpu_read_chk($sformatf("t2_p1_rd%0d", i), BASE + 16'd1, 1'b0);
        for (int i = 0; i < 3; i++) cpu_read_chk($sformatf("t2_p0_rd%0d", i), BASE, 1'b1);

        // ---- 3: port independence ----
        cpu_write(BASE, 8'h00);
        repeat (60) tick();
        chk("t3_idle", 32'(busy), 32'd0);
        cpu_read_chk("t3_p1_b0", BASE + 16'd1, 1'b0);
        cpu_read_chk("t3_p1_b1", BASE + 16'd1, 1'b1);
        cpu_read_chk("t3_p0_b0", BASE, 1'b1);

        // ---- 4: second request while busy is queued ----
        pad_btn0 = 8'h3C;
        cpu_write(BASE, 8'h01);
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        latch_rise = 0; prev_latch = 1'b0; latch_at55 = 1'b0;
        for (int t = 0; t <= 130; t++) begin
            if (t == 0 || t == 20) begin
                r_en = 1'b0; addr = BASE; w_data = 8'h00;
            end else if (t == 19) begin
                r_en = 1'b0; addr = BASE; w_data = 8'h01;
            end else begin
                idle_bus();
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = t;
                busy_last = t;
            end
            if (ctlr_latch && !prev_latch) latch_rise++;
            if (t == 55) latch_at55 = ctlr_latch;
            prev_latch = ctlr_latch;
            tick();
        end
        idle_bus();
        chk("t4_busy_first", 32'(busy_first), 32'd1);
        chk("t4_busy_last",  32'(busy_last), 32'd108);
        chk("t4_busy_cont",  32'(busy_cnt), 32'd108);
        chk("t4_latch_rises", 32'(latch_rise), 32'd2);
        chk("t4_latch_at55", 32'(latch_at55), 32'd1);
        rd_val = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1; addr = BASE;
            tick();
            rd_val = {button_data_rd[0], rd_val[7:1]};
        end
        idle_bus();
        chk("t4_snapshot", 32'(rd_val), 32'h3C);
        cpu_read_chk("t4_saturated", BASE, 1'b1);

        // ---- 5: reset mid-capture aborts with no commit ----
        pad_btn0 = 8'hFF;
        pad_btn1 = 8'hFF;
        cpu_write(BASE, 8'h01);
        r_en = 1'b0; addr = BASE; w_data = 8'h00;
        for (int t = 0; t < 30; t++) begin
            tick();
            idle_bus();
        end
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_latch", 32'(ctlr_latch), 32'd0);
        chk("t5_pulse", 32'(ctlr_pulse), 32'h3);
        chk("t5_data",  32'(button_data_rd), 32'd0);
        chk("t5_hit",   32'(rd_hit), 32'd0);
        chk("t5_busy",  32'(busy), 32'd0);
        repeat (60) tick();
        chk("t5_no_commit_busy", 32'(busy), 32'd0);
        cpu_read_chk("t5_p0_b0", BASE, 1'b0);
        cpu_read_chk("t5_p1_b0", BASE + 16'd1, 1'b0);
        cpu_read_chk("t5_p0_b1", BASE, 1'b0);

        // ---- 6: auto-poll with clock_en at half rate ----
        begin
            int   starts [$];
            int   freeze_viol;
            logic prev_busy2;
            logic [12:0] prev_out;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            freeze_viol = 0;
            prev_busy2 = busy2;
            for (int c = 0; c < 900; c++) begin
                clock_en2 = (c % 2 == 0);
                prev_out = {busy2, ctlr_latch2, ctlr_pulse2, rd_hit2, button_data_rd2};
                tick();
                if (!clock_en2 && ({busy2, ctlr_latch2, ctlr_pulse2, rd_hit2, button_data_rd2} != prev_out))
                    freeze_viol++;
                if (busy2 && !prev_busy2) starts.push_back(c);
                prev_busy2 = busy2;
            end
            clock_en2 = 1'b0;
            chk("t6_freeze", 32'(freeze_viol), 32'd0);
            chk("t6_num_starts", 32'(starts.size()), 32'd4);
            if (starts.size() > 0) chk("t6_first_start", 32'(starts[0]), 32'd198);
            for (int i = 1; i < starts.size(); i++)
                chk($sformatf("t6_period%0d", i), 32'(starts[i] - starts[i-1]), 32'd200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
